temporal_capture: RTL
=====================

Name: temporal_capture

Overview:
- Receive-side partner of the shared rollover time-base counter in the temporal-LUT multiplier datapath.
- Consumes the counter's time stamp and rollover pulse together with a 1-bit temporal/unary stream.
- Converts each 2^WIDTH-step window back to binary: the ones-count (rate code) and the first-arrival time stamp (time code).
- Results are buffered in a 2-entry output FIFO with a valid/ready handshake.

Parameters:
- WIDTH, 8: time-stamp width; one window is 2^WIDTH enabled cycles; equals the codebase INPUT_WIDTH.

Ports:
- clk  in  1  clock; all logic on its rising edge
- rst  in  1  asynchronous reset, active-high
- enable  in  1  time-base advance; identical to the enable driving the time-base counter
- cnt_in  in  WIDTH  current time stamp from the counter
- rollover_in  in  1  counter rollover (cnt_in==0 & enable); marks the first step of a window
- unary_in  in  1  temporal stream sample; valid only when enable=1
- out_valid  out  1  FIFO head holds a completed window result
- out_ready  in  1  consumer accepts the head when out_valid & out_ready
- out_count  out  WIDTH+1  number of enabled steps with unary_in=1 in the window (0..2^WIDTH)
- out_first  out  WIDTH  cnt_in at the first enabled step with unary_in=1; 0 if none
- out_hit  out  1  at least one 1 seen in the window
- drop  out  1  sticky; a completed window was discarded because the FIFO was full

Behaviour:
- Reset: state=SYNC, accumulators=0, FIFO empty. out_valid=0, out_count=0, out_first=0, out_hit=0, drop=0. Reset mid-window discards the partial window and all buffered results.
- enable=0: accumulators frozen; unary_in, cnt_in and rollover_in are ignored. The FIFO still pops on handshake.
- State SYNC:
  - Ignore all samples.
  - On rollover_in=1, go to ACC. That cycle is step 0 of the first window: acc_count=unary_in, hit=unary_in, first=0.
- State ACC, enabled cycle with rollover_in=0:
  - acc_count += unary_in.
  - If unary_in=1 and hit=0: first <= cnt_in, hit <= 1.
- State ACC, enabled cycle with rollover_in=1 (window close):
  - Push {acc_count, first, hit} of the finished window into the FIFO.
  - In the same cycle, restart the accumulators with this cycle's sample as step 0 of the new window, as in SYNC. No sample is lost or double-counted.
- Arithmetic: acc_count is WIDTH+1 bits and saturates naturally at 2^WIDTH (max steps per window), so it never wraps. The first field is never overwritten once hit=1.
- cnt_in is trusted. No check of step count versus cnt_in.
- FIFO: 2 entries, registered outputs. Window closed at edge t is visible on out_valid/out_* after edge t. Head is stable while out_valid=1 and out_ready=0.
- Pop: occurs on out_valid & out_ready.
- Simultaneous push and pop:
  - FIFO full: the pop frees a slot and the push is accepted; no drop.
  - FIFO empty: not possible (out_valid=0 when empty).
- Full without pop at window close: new result discarded, older entries kept, drop <= 1. drop stays 1 until rst.
- out_* are 0 when the FIFO is empty.

Test Plan:
- WIDTH=3, enable=1 always, rollover every 8 cycles, out_ready=1. Stream after first rollover: 0,0,1,1,0,1,0,0 (cnt 0..7) -> one cycle after next rollover: out_valid=1, out_count=3, out_first=2, out_hit=1.
- All-ones window: unary_in=1 for all 8 steps -> out_count=8, out_first=0, out_hit=1. All-zeros window -> out_count=0, out_first=0, out_hit=0.
- Stream of ones before the first rollover, then zeros -> no output before the first full window; first result out_count=0.
- enable toggled 1/0 every cycle, stream 1 on every enabled step -> window spans 16 clocks, out_count=8, and samples on disabled cycles are ignored.
- out_ready=0 for 3 windows with counts 1,2,3 -> FIFO holds 1,2; third dropped; drop=1. Release ready -> pops 1 then 2, then out_valid=0; drop remains 1.
- FIFO full, out_ready=1 on the exact window-close cycle -> no drop, next head correct. Assert rst mid-window -> all outputs 0 immediately; after release, outputs stay idle until a rollover followed by a full window.

Source files
------------

// File: rtl/temporal_capture.sv
// Temporal capture: folds one 2^WIDTH-step unary window back to a rate code
// and a first-arrival time code, buffered in a 2-entry valid/ready FIFO.
//
// state  | meaning
// S_SYNC | waiting for the first rollover; all samples ignored
// S_ACC  | accumulating a window; each rollover closes it and starts the next
module temporal_capture #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             rollover_in,
  input  logic             unary_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_count,
  output logic [WIDTH-1:0] out_first,
  output logic             out_hit,
  output logic             drop
);

  localparam int ENT_W = 2 * WIDTH + 2;
  localparam logic [WIDTH:0] ACC_MAX = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0] ACC_ONE = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic {S_SYNC, S_ACC} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH:0]   r_acc_count, w_acc_count_nxt;
  logic [WIDTH-1:0] r_first, w_first_nxt;
  logic             r_hit, w_hit_nxt;
  logic             w_close;

  logic [ENT_W-1:0] r_head, r_tail;
  logic             r_head_v, r_tail_v, r_drop;
  logic [ENT_W-1:0] w_entry;
  logic             w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_SYNC;
      r_acc_count <= '0;
      r_first     <= '0;
      r_hit       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc_count <= w_acc_count_nxt;
      r_first     <= w_first_nxt;
      r_hit       <= w_hit_nxt;
    end
  end

  // A rollover always restarts the accumulators with its own sample as step 0.
  always_comb begin
    w_state_nxt     = r_state;
    w_acc_count_nxt = r_acc_count;
    w_first_nxt     = r_first;
    w_hit_nxt       = r_hit;
    w_close         = 1'b0;
    if (enable) begin
      if (rollover_in) begin
        w_close         = (r_state == S_ACC);
        w_state_nxt     = S_ACC;
        w_acc_count_nxt = {{WIDTH{1'b0}}, unary_in};
        w_hit_nxt       = unary_in;
        w_first_nxt     = '0;
      end else if (r_state == S_ACC && unary_in) begin
        if (r_acc_count != ACC_MAX) w_acc_count_nxt = r_acc_count + ACC_ONE;
        if (!r_hit) begin
          w_first_nxt = cnt_in;
          w_hit_nxt   = 1'b1;
        end
      end
    end
  end

  assign w_entry = {r_acc_count, r_first, r_hit};
  assign w_pop   = r_head_v & out_ready;

  // Head is cleared whenever it empties so the outputs read zero when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_head_v <= 1'b0;
      r_tail_v <= 1'b0;
      r_drop   <= 1'b0;
    end else if (w_pop) begin
      if (r_tail_v) begin
        r_head <= r_tail;
        if (w_close) begin
          r_tail <= w_entry;
        end else begin
          r_tail   <= '0;
          r_tail_v <= 1'b0;
        end
      end else if (w_close) begin
        r_head <= w_entry;
      end else begin
        r_head   <= '0;
        r_head_v <= 1'b0;
      end
    end else if (w_close) begin
      if (!r_head_v) begin
        r_head   <= w_entry;
        r_head_v <= 1'b1;
      end else if (!r_tail_v) begin
        r_tail   <= w_entry;
        r_tail_v <= 1'b1;
      end else begin
        r_drop <= 1'b1;
      end
    end
  end

  assign out_valid                       = r_head_v;
  assign {out_count, out_first, out_hit} = r_head;
  assign drop                            = r_drop;

endmodule
